// File: rtl/traffic_pkg.sv
// Shared encodings and LFSR helpers for the traffic generator/checker.
package traffic_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_INC   = 2'd0;
    localparam mode_t MODE_LFSR  = 2'd1;
    localparam mode_t MODE_FIXED = 2'd2;
    localparam mode_t MODE_RSVD  = 2'd3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BURST = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    // Tap masks: bit n-1 set for each x^n term of the feedback polynomial
    localparam logic [31:0] LFSR_TAPS_8  = 32'h0000_00B8;
    localparam logic [31:0] LFSR_TAPS_16 = 32'h0000_D008;
    localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;

    function automatic logic [31:0] lfsr_taps(input int unsigned dw);
        case (dw)
            8:       return LFSR_TAPS_8;
            16:      return LFSR_TAPS_16;
            default: return LFSR_TAPS_32;
        endcase
    endfunction

    // Fibonacci step, shifting left with feedback into bit 0; caller truncates to dw bits.
    function automatic logic [31:0] lfsr_next(input logic [31:0] cur, input int unsigned dw);
        logic fb;
        fb = ^(cur & lfsr_taps(dw));
        return {cur[30:0], fb};
    endfunction

endpackage

// File: rtl/traffic_gen_chk_pat_lane.sv
// One lane of pattern generation (INC / LFSR / FIXED); shared by the TX side and the checker.
module pat_lane
    import traffic_pkg::*;
#(
    parameter int unsigned DW   = 8,
    parameter int unsigned LANE = 0
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [1:0]    mode_i,
    input  logic [DW-1:0] seed_i,
    input  logic          load_i,
    input  logic          advance_i,
    output logic [DW-1:0] value_o
);

    localparam logic [DW-1:0] LANE_OFS = DW'(LANE);

    logic [1:0]    mode_q;
    logic [DW-1:0] value_q;
    logic [DW-1:0] value_d;
    logic [DW-1:0] lfsr_seed_s;
    logic [DW-1:0] init_s;
    logic [DW-1:0] step_s;

    // An all-zero LFSR state would lock up, so it is replaced by 1
    assign lfsr_seed_s = ((seed_i ^ LANE_OFS) == '0) ? DW'(1'b1) : (seed_i ^ LANE_OFS);

    // First value of the lane for the mode being loaded
    always_comb begin
        init_s = seed_i;
        case (mode_i)
            MODE_INC:  init_s = seed_i + LANE_OFS;
            MODE_LFSR: init_s = lfsr_seed_s;
            default:   init_s = seed_i;
        endcase
    end

    // Successor value for the latched mode
    always_comb begin
        step_s = value_q;
        case (mode_q)
            MODE_INC:  step_s = value_q + DW'(1'b1);
            MODE_LFSR: step_s = DW'(lfsr_next(32'(value_q), DW));
            default:   step_s = value_q;
        endcase
    end

    // Load has priority over advance
    always_comb begin
        value_d = value_q;
        if (load_i) begin
            value_d = init_s;
        end else if (advance_i) begin
            value_d = step_s;
        end else begin
            value_d = value_q;
        end
    end

    // Lane state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mode_q  <= 2'd0;
            value_q <= '0;
        end else begin
            if (load_i) begin
                mode_q <= mode_i;
            end else begin
                mode_q <= mode_q;
            end
            value_q <= value_d;
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/traffic_gen_chk.sv
// Multi-lane burst/gap traffic source with an optional per-lane returned-data checker.
// Checker is built only when TRAFFIC_CHECKER_EN is defined; otherwise err_cnt reads 0.
module traffic_gen_chk
    import traffic_pkg::*;
#(
    parameter int unsigned LANES = 4,
    parameter int unsigned DW    = 8,
    parameter int unsigned CW    = 8,
    parameter int unsigned ECW   = 8
) (
    input  logic                 clk_f,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stop,
    input  logic [1:0]           mode,
    input  logic [DW-1:0]        seed,
    input  logic [CW-1:0]        burst_len,
    input  logic [CW-1:0]        gap_len,
    output logic [LANES*DW-1:0]  data_out,
    output logic [LANES-1:0]     valid_out,
    input  logic [LANES*DW-1:0]  data_in,
    input  logic [LANES-1:0]     valid_in,
    output logic                 busy,
    output logic [LANES*ECW-1:0] err_cnt
);

    if (!(DW == 8 || DW == 16 || DW == 32)) begin : g_bad_dw
        $error("traffic_gen_chk: DW must be 8, 16 or 32");
    end

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] blen_q, blen_d;
    logic [CW-1:0] glen_q, glen_d;
    logic [CW-1:0] beat_cnt_q, beat_cnt_d;
    logic [CW-1:0] gap_cnt_q, gap_cnt_d;
    logic          stop_seen_q, stop_seen_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;
    logic          load_s;
    logic          adv_s;
    logic [CW-1:0] blen_eff_s;
    logic          last_beat_s;

    assign blen_eff_s  = (blen_q == '0) ? CW'(1'b1) : blen_q;
    assign last_beat_s = (beat_cnt_q == blen_eff_s);

    // Framing FSM; adv_s steps the TX pattern whenever another beat follows the current one
    always_comb begin
        state_d     = state_q;
        blen_d      = blen_q;
        glen_d      = glen_q;
        beat_cnt_d  = beat_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        stop_seen_d = stop_seen_q;
        load_s      = 1'b0;
        adv_s       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_BURST;
                    blen_d      = burst_len;
                    glen_d      = gap_len;
                    beat_cnt_d  = CW'(1'b1);
                    stop_seen_d = stop;
                    load_s      = 1'b1;
                end else begin
                    stop_seen_d = 1'b0;
                end
            end
            ST_BURST: begin
                if (!last_beat_s) begin
                    beat_cnt_d  = beat_cnt_q + CW'(1'b1);
                    stop_seen_d = stop_seen_q | stop;
                    adv_s       = 1'b1;
                end else if (stop_seen_q || stop) begin
                    state_d     = ST_IDLE;
                    stop_seen_d = 1'b0;
                end else if (glen_q == '0) begin
                    beat_cnt_d  = CW'(1'b1);
                    stop_seen_d = 1'b0;
                    adv_s       = 1'b1;
                end else begin
                    state_d     = ST_GAP;
                    gap_cnt_d   = CW'(1'b1);
                    stop_seen_d = 1'b0;
                end
            end
            ST_GAP: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (gap_cnt_q == glen_q) begin
                    state_d    = ST_BURST;
                    beat_cnt_d = CW'(1'b1);
                    adv_s      = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q + CW'(1'b1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        valid_d = (state_d == ST_BURST);
        busy_d  = (state_d != ST_IDLE);
    end

    // FSM and registered status outputs
    always_ff @(posedge clk_f or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            blen_q      <= '0;
            glen_q      <= '0;
            beat_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            stop_seen_q <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            blen_q      <= blen_d;
            glen_q      <= glen_d;
            beat_cnt_q  <= beat_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            stop_seen_q <= stop_seen_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
        end
    end

    assign valid_out = {LANES{valid_q}};
    assign busy      = busy_q;

    for (genvar i = 0; i < LANES; i++) begin : g_tx
        pat_lane #(.DW(DW), .LANE(i)) u_tx (
            .clk_i     (clk_f),
            .rst_ni    (reset),
            .mode_i    (mode),
            .seed_i    (seed),
            .load_i    (load_s),
            .advance_i (adv_s),
            .value_o   (data_out[i*DW +: DW])
        );
    end

`ifdef TRAFFIC_CHECKER_EN
    for (genvar i = 0; i < LANES; i++) begin : g_chk
        logic [DW-1:0]  exp_s;
        logic [ECW-1:0] err_q, err_d;

        pat_lane #(.DW(DW), .LANE(i)) u_exp (
            .clk_i     (clk_f),
            .rst_ni    (reset),
            .mode_i    (mode),
            .seed_i    (seed),
            .load_i    (load_s),
            .advance_i (valid_in[i]),
            .value_o   (exp_s)
        );

        // Saturating mismatch count, cleared when new traffic starts
        always_comb begin
            err_d = err_q;
            if (load_s) begin
                err_d = '0;
            end else if (valid_in[i] && (data_in[i*DW +: DW] != exp_s) && (err_q != '1)) begin
                err_d = err_q + ECW'(1'b1);
            end else begin
                err_d = err_q;
            end
        end

        // Error counter register
        always_ff @(posedge clk_f or negedge reset) begin
            if (!reset) begin
                err_q <= '0;
            end else begin
                err_q <= err_d;
            end
        end

        assign err_cnt[i*ECW +: ECW] = err_q;
    end
`else
    logic unused_chk_s;
    assign unused_chk_s = ^{data_in, valid_in};
    assign err_cnt      = '0;
`endif

endmodule

// File: tb/tb_traffic_gen_chk.sv
// Self-checking bench: a trace-level reference model of framing, patterns and loopback errors.
`timescale 1ns/1ps
module tb_traffic_gen_chk;

    localparam int LANES = 4;
    localparam int DW    = 8;
    localparam int CW    = 8;
    localparam int ECW   = 8;

    logic                 clk_f = 1'b0;
    logic                 reset;
    logic                 start;
    logic                 stop;
    logic [1:0]           mode;
    logic [DW-1:0]        seed;
    logic [CW-1:0]        burst_len;
    logic [CW-1:0]        gap_len;
    logic [LANES*DW-1:0]  data_out;
    logic [LANES-1:0]     valid_out;
    logic [LANES*DW-1:0]  data_in;
    logic [LANES-1:0]     valid_in;
    logic                 busy;
    logic [LANES*ECW-1:0] err_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic                v;
        logic                b;
        logic                dchk;
        logic [LANES*DW-1:0] d;
    } exp_t;

    exp_t                exp_q[$];
    logic [LANES*DW-1:0] obs_d[$];
    logic                obs_v[$];
    logic [LANES*DW-1:0] lb_d[$];
    logic [LANES-1:0]    lb_v[$];

    traffic_gen_chk #(.LANES(LANES), .DW(DW), .CW(CW), .ECW(ECW)) dut (
        .clk_f     (clk_f),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .mode      (mode),
        .seed      (seed),
        .burst_len (burst_len),
        .gap_len   (gap_len),
        .data_out  (data_out),
        .valid_out (valid_out),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .busy      (busy),
        .err_cnt   (err_cnt)
    );

    always #5 clk_f = ~clk_f;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] ref_first(input logic [1:0] m, input logic [DW-1:0] s, input int lane);
        logic [DW-1:0] x;
        case (m)
            2'd0: return s + DW'(lane);
            2'd1: begin
                x = s ^ DW'(lane);
                return (x == 8'h00) ? 8'h01 : x;
            end
            default: return s;
        endcase
    endfunction

    // x^8+x^6+x^5+x^4+1: new bit is the XOR of stages 8,6,5,4
    function automatic logic [DW-1:0] ref_next(input logic [1:0] m, input logic [DW-1:0] v);
        case (m)
            2'd0:    return v + 8'd1;
            2'd1:    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
            default: return v;
        endcase
    endfunction

    // Expected cycle-by-cycle trace from the framing rules; stop_k = cycle holding the stop pulse
    task automatic build_trace(input logic [1:0] m, input logic [DW-1:0] s, input int blen,
                               input int glen, input int stop_k);
        logic [DW-1:0] cur [LANES];
        int   k;
        int   bl;
        bit   done;
        bit   first;
        bit   saw;
        exp_t e;
        k     = 0;
        done  = 1'b0;
        first = 1'b1;
        exp_q.delete();
        bl = (blen == 0) ? 1 : blen;
        for (int l = 0; l < LANES; l++) cur[l] = ref_first(m, s, l);
        while (!done) begin
            saw = first && (stop_k < 0);
            for (int n = 0; n < bl; n++) begin
                if (!first) begin
                    for (int l = 0; l < LANES; l++) cur[l] = ref_next(m, cur[l]);
                end
                first = 1'b0;
                e.v = 1'b1; e.b = 1'b1; e.dchk = 1'b1;
                for (int l = 0; l < LANES; l++) e.d[l*DW +: DW] = cur[l];
                exp_q.push_back(e);
                if (k == stop_k) saw = 1'b1;
                k++;
            end
            if (saw) begin
                done = 1'b1;
            end else begin
                for (int g = 0; g < glen && !done; g++) begin
                    e.v = 1'b0; e.b = 1'b1; e.dchk = 1'b1;
                    exp_q.push_back(e);
                    if (k == stop_k) done = 1'b1;
                    k++;
                end
            end
        end
        for (int t = 0; t < 4; t++) begin
            e.v = 1'b0; e.b = 1'b0; e.dchk = 1'b0;
            exp_q.push_back(e);
        end
    endtask

    // Runs one traffic session with a 3-cycle loopback; bit0 of lane clane is flipped on
    // returned beats cfrom..cto. A start pulse while busy is injected to prove it is ignored.
    task automatic run_case(input string tag, input logic [1:0] m, input logic [DW-1:0] s,
                            input int blen, input int glen, input int stop_k,
                            input int clane, input int cfrom, input int cto);
        int                  flips;
        int                  ret_idx;
        logic [LANES*DW-1:0] din;
        logic [LANES-1:0]    vin;
        int                  exp_err;
        flips   = 0;
        ret_idx = 0;
        build_trace(m, s, blen, glen, stop_k);
        obs_d.delete(); obs_v.delete(); lb_d.delete(); lb_v.delete();
        for (int t = 0; t < 3; t++) begin
            lb_d.push_back('0);
            lb_v.push_back('0);
        end
        mode      = m;
        seed      = s;
        burst_len = CW'(blen);
        gap_len   = CW'(glen);
        start     = 1'b1;
        stop      = (stop_k < 0);
        @(posedge clk_f); #1;
        start = 1'b0;
        stop  = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            check_eq($sformatf("%s valid[%0d]", tag, i), 64'(valid_out), 64'({LANES{exp_q[i].v}}));
            check_eq($sformatf("%s busy[%0d]", tag, i), 64'(busy), 64'(exp_q[i].b));
            if (exp_q[i].dchk) begin
                check_eq($sformatf("%s data[%0d]", tag, i), 64'(data_out), 64'(exp_q[i].d));
            end
            obs_d.push_back(data_out);
            obs_v.push_back(valid_out[0]);
            lb_d.push_back(data_out);
            lb_v.push_back(valid_out);
            din = lb_d.pop_front();
            vin = lb_v.pop_front();
            if (vin[clane]) begin
                if (ret_idx >= cfrom && ret_idx <= cto) begin
                    din[clane*DW] = ~din[clane*DW];
                    flips++;
                end
                ret_idx++;
            end
            data_in  = din;
            valid_in = vin;
            stop     = (i == stop_k);
            if (i == 1 && exp_q[1].b) begin
                start     = 1'b1;
                seed      = ~s;
                mode      = m + 2'd1;
                burst_len = 8'd3;
                gap_len   = 8'd7;
            end else begin
                start = 1'b0;
            end
            @(posedge clk_f); #1;
        end
        stop     = 1'b0;
        valid_in = '0;
        for (int l = 0; l < LANES; l++) begin
`ifdef TRAFFIC_CHECKER_EN
            exp_err = (l == clane) ? ((flips > 255) ? 255 : flips) : 0;
`else
            exp_err = 0;
`endif
            check_eq($sformatf("%s err_cnt[%0d]", tag, l), 64'(err_cnt[l*ECW +: ECW]), 64'(exp_err));
        end
    endtask

    initial begin
        int rm, rb, rg, rk, rl, rf;
        logic [DW-1:0] rs;
        reset     = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        mode      = 2'd0;
        seed      = '0;
        burst_len = '0;
        gap_len   = '0;
        data_in   = '0;
        valid_in  = '0;
        repeat (3) @(posedge clk_f);
        #1 reset = 1'b1;
        check_eq("rst valid", 64'(valid_out), 64'(0));
        check_eq("rst data", 64'(data_out), 64'(0));
        check_eq("rst busy", 64'(busy), 64'(0));
        check_eq("rst err", 64'(err_cnt), 64'(0));
        @(posedge clk_f); #1;

        run_case("inc", 2'd0, 8'hCC, 2, 1, 3, 0, 1, 0);
        check_eq("inc l0 b0", 64'(obs_d[0][7:0]), 64'(8'hCC));
        check_eq("inc l0 b1", 64'(obs_d[1][7:0]), 64'(8'hCD));
        check_eq("inc l3 b0", 64'(obs_d[0][31:24]), 64'(8'hCF));
        check_eq("inc l3 b1", 64'(obs_d[1][31:24]), 64'(8'hD0));
        check_eq("inc gap", 64'(obs_v[2]), 64'(0));
        check_eq("inc l0 b2", 64'(obs_d[3][7:0]), 64'(8'hCE));

        run_case("startstop", 2'd3, 8'h5A, 3, 2, -1, 0, 1, 0);

        run_case("lfsr", 2'd1, 8'h00, 128, 0, 128, 0, 1, 0);
        check_eq("lfsr first", 64'(obs_d[0][7:0]), 64'(8'h01));
        check_eq("lfsr wrap", 64'(obs_d[255][7:0]), 64'(8'h01));

        run_case("loop100", 2'd0, 8'hF0, 50, 3, 60, 0, 1, 0);
        run_case("flip1", 2'd0, 8'h33, 10, 2, 0, 2, 5, 5);
        run_case("sat", 2'd1, 8'hA5, 100, 0, 200, 2, 0, 1000);
        run_case("stopgap", 2'd0, 8'h40, 3, 4, 4, 0, 1, 0);
        check_eq("stopgap idle", 64'(obs_v[5]), 64'(0));

        // Asynchronous reset in the middle of a burst
        mode = 2'd0; seed = 8'h10; burst_len = 8'd20; gap_len = 8'd0;
        start = 1'b1; stop = 1'b0;
        @(posedge clk_f); #1 start = 1'b0;
        repeat (3) begin
            @(posedge clk_f); #1;
        end
        check_eq("pre-rst valid", 64'(valid_out), 64'(4'hF));
        #2 reset = 1'b0;
        #1;
        check_eq("midrst valid", 64'(valid_out), 64'(0));
        check_eq("midrst data", 64'(data_out), 64'(0));
        check_eq("midrst busy", 64'(busy), 64'(0));
        check_eq("midrst err", 64'(err_cnt), 64'(0));
        @(posedge clk_f); #1 reset = 1'b1;
        repeat (5) begin
            @(posedge clk_f); #1;
            check_eq("postrst valid", 64'(valid_out), 64'(0));
            check_eq("postrst busy", 64'(busy), 64'(0));
        end

        for (int r = 0; r < 8; r++) begin
            rm = int'($urandom_range(0, 3));
            rs = 8'($urandom);
            rb = int'($urandom_range(0, 6));
            rg = int'($urandom_range(0, 4));
            rk = int'($urandom_range(0, 20)) - 1;
            rl = int'($urandom_range(0, 3));
            rf = int'($urandom_range(0, 5));
            run_case($sformatf("rnd%0d", r), 2'(rm), rs, rb, rg, rk, rl, rf,
                     rf + int'($urandom_range(0, 8)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/traffic_gen_chk.md
Name: traffic_gen_chk

Overview:
- Synthesizable, parametrised successor of the phy_tx lane stimulus source.
- Drives LANES parallel DW-bit data/valid pairs with programmable burst/gap framing and selectable data patterns.
- Regenerates the same sequence to check data returned from the receive path (recirculator outputs) per lane.
- Sits in front of phy_tx in loopback benches and in on-chip BIST.

Parameters:
LANES, 4, number of parallel lanes
DW, 8, data width per lane; 8, 16 or 32 only, any other value is an elaboration error
CW, 8, width of burst_len/gap_len counters
ECW, 8, width of each per-lane error counter

Ports:
clk_f  in  1  single clock
reset  in  1  asynchronous, active-low reset
start  in  1  pulse; begins traffic when idle
stop  in  1  level/pulse; ends traffic after current burst
mode  in  2  0=INC, 1=LFSR, 2=FIXED, 3=reserved (treated as FIXED)
seed  in  DW  base value / LFSR seed
burst_len  in  CW  valid beats per burst
gap_len  in  CW  idle cycles between bursts
data_out  out  LANES*DW  lane i at bits [i*DW +: DW]
valid_out  out  LANES  all bits equal; one valid per lane
data_in  in  LANES*DW  returned data
valid_in  in  LANES  returned valids, per lane
busy  out  1  high in BURST or GAP
err_cnt  out  LANES*ECW  per-lane mismatch count

Behaviour:
- Reset (async assert, sync release): data_out=0, valid_out=0, busy=0, err_cnt=0, FSM=IDLE; applies mid-operation, next traffic needs new start.
- FSM IDLE/BURST/GAP:
  - IDLE: start=1 latches mode, seed, burst_len, gap_len -> BURST; first valid_out beat next cycle.
  - BURST: valid_out=all 1s for burst_len cycles (0 treated as 1). At last beat: stop seen since last burst start -> IDLE; else gap_len=0 -> BURST (back-to-back); else -> GAP.
  - GAP: valid_out=0, data_out holds last value, gap_len cycles, then BURST; stop during GAP -> IDLE next cycle.
- start while busy ignored; start and stop same cycle in IDLE -> exactly one burst then IDLE.
- Inputs other than start/stop ignored outside IDLE.
- Pattern per lane i, advancing only on valid beats:
  - INC: seed+i, then +1 per beat, modulo 2^DW (wraps FF->00 for DW=8).
  - LFSR: Fibonacci, seeded seed^i (all-zero seed replaced by 1), one shift per beat. Polynomials: DW=8 x^8+x^6+x^5+x^4+1; DW=16 x^16+x^15+x^13+x^4+1; DW=32 x^32+x^22+x^2+x+1.
  - FIXED: seed every beat.
- Checker, per lane:
  - Expected generator reset to lane seed on start.
  - Advances only when valid_in[i]=1.
  - data_in lane != expected -> err_cnt lane +1, saturating at 2^ECW-1.
  - err_cnt cleared on start, otherwise held (readable after IDLE).
  - valid_in=0 cycles neither compare nor advance (arbitrary loopback latency tolerated).

Optional Feature:
- TRAFFIC_CHECKER_EN defined: checker present as above.
- Undefined: checker logic absent; err_cnt constant 0; data_in/valid_in unused.

Decomposition:
- Package traffic_pkg: mode encodings, FSM state encoding, LFSR tap constants per DW, function computing next LFSR value.
- One sub-module pat_lane (DW param): seed, mode, load, advance -> current value; instantiated LANES times for TX and LANES times for the checker.

Test Plan:
- INC, seed=8'hCC, burst_len=2, gap_len=1, start -> lane0 CC,CD; lane3 CF,D0; one idle cycle; CE next burst.
- LFSR, seed=8'h00 -> lane0 starts 01; sequence matches reference model for 255 beats, wraps to 01.
- Loopback data_out->data_in with 3-cycle delay, 100 beats -> err_cnt all 0.
- Flip bit0 of lane2 returned data on beat 5 -> err_cnt lane2=1, others 0; 300 forced errors -> lane2 saturates at 255.
- stop asserted during GAP with gap_len=4 -> IDLE next cycle, busy=0, no further valid.
- reset low mid-BURST -> all outputs 0 immediately; after release no valid until start.
